// File: rtl/buffer_stream_port.sv
// Command-driven stream port that moves a run of words between a buffer slot and a
// read/write stream, with a fixed-latency read return path tracked by a valid shift register.

package buffer_stream_pkg;
  localparam int E          = 4;
  localparam int FSIZE      = 8;
  localparam int SLOT_NUM   = 4;
  localparam int BUF_ADDR_W = 32;

  typedef struct packed {
    logic [BUF_ADDR_W-1:0] raddr;
    logic [BUF_ADDR_W-1:0] waddr;
    logic [E*FSIZE-1:0]    wdata;
    logic                  wren;
  } BufferRAMTEFsizeInputs;
endpackage

// state | meaning
// IDLE  | waiting for a command; cmd_ready high
// READ  | issuing one raddr per cycle
// WRITE | accepting write beats, one wren per beat
// DRAIN | all reads issued; waiting for the last word to return
module buffer_stream_port
  import buffer_stream_pkg::*;
#(
  parameter int DATA_SIZE  = E * FSIZE,
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 16,
  parameter int RD_LATENCY = 4
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_write,
  input  logic [ADDR_W-1:0]           cmd_base,
  input  logic [LEN_W-1:0]            cmd_len,
  input  logic [$clog2(SLOT_NUM)-1:0] cmd_slot,
  output logic [$clog2(SLOT_NUM)-1:0] slot_sel,
  output BufferRAMTEFsizeInputs       ram_req,
  input  logic [DATA_SIZE-1:0]        ram_rdata,
  input  logic [DATA_SIZE-1:0]        wr_data,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  output logic [DATA_SIZE-1:0]        rd_data,
  output logic                        rd_valid,
  output logic                        busy,
  output logic                        done
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DRAIN} state_t;

  state_t                  state;
  logic [LEN_W-1:0]        rem;
  logic [ADDR_W-1:0]       wr_ptr;
  logic [ADDR_W-1:0]       rd_addr;
  logic [ADDR_W-1:0]       wr_addr;
  logic [DATA_SIZE-1:0]    wr_word;
  logic                    wr_en;
  logic [RD_LATENCY-1:0]   vld_sr;
  logic [RD_LATENCY-1:0]   vld_next;
  logic [RD_LATENCY-1:0]   vld_last;
  logic                    accept;
  logic                    issue;

  assign accept = cmd_valid && cmd_ready;
  // The first read is issued on the accept edge itself, later ones from READ.
  assign issue  = (accept && !cmd_write && (cmd_len != '0)) || (state == READ);

  always_comb begin
    vld_next    = vld_sr << 1;
    vld_next[0] = issue;
    vld_last    = '0;
    vld_last[RD_LATENCY-1] = 1'b1;
  end

  assign ram_req = '{raddr: rd_addr, waddr: wr_addr, wdata: wr_word, wren: wr_en};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      wr_ready  <= 1'b0;
      wr_en     <= 1'b0;
      rd_addr   <= '0;
      wr_addr   <= '0;
      wr_word   <= '0;
      wr_ptr    <= '0;
      rem       <= '0;
      slot_sel  <= '0;
      vld_sr    <= '0;
    end else begin
      done     <= 1'b0;
      wr_en    <= 1'b0;
      vld_sr   <= vld_next;
      rd_valid <= vld_sr[RD_LATENCY-1];
      if (vld_sr[RD_LATENCY-1]) rd_data <= ram_rdata;

      case (state)
        IDLE: begin
          if (accept) begin
            slot_sel <= cmd_slot;
            if (cmd_len == '0) begin
              done <= 1'b1;
            end else if (cmd_write) begin
              wr_ptr    <= cmd_base;
              rem       <= cmd_len;
              state     <= WRITE;
              wr_ready  <= 1'b1;
              cmd_ready <= 1'b0;
              busy      <= 1'b1;
            end else begin
              rd_addr   <= cmd_base;
              rem       <= cmd_len - LEN_W'(1);
              state     <= (cmd_len == LEN_W'(1)) ? DRAIN : READ;
              cmd_ready <= 1'b0;
              busy      <= 1'b1;
            end
          end
        end

        READ: begin
          rd_addr <= rd_addr + ADDR_W'(1);
          rem     <= rem - LEN_W'(1);
          if (rem == LEN_W'(1)) state <= DRAIN;
        end

        DRAIN: begin
          // Only the final word remains in flight once it reaches the top stage alone.
          if (vld_sr == vld_last) begin
            done      <= 1'b1;
            state     <= IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end

        WRITE: begin
          if (wr_valid) begin
            wr_addr <= wr_ptr;
            wr_word <= wr_data;
            wr_en   <= 1'b1;
            wr_ptr  <= wr_ptr + ADDR_W'(1);
            rem     <= rem - LEN_W'(1);
            if (rem == LEN_W'(1)) begin
              done      <= 1'b1;
              state     <= IDLE;
              wr_ready  <= 1'b0;
              cmd_ready <= 1'b1;
              busy      <= 1'b0;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_buffer_stream_port.sv
// Directed bench for buffer_stream_port: a table of read commands plus hand-written
// write, zero-length, reset-abort and back-to-back sequences.

module tb_buffer_stream_port;
  import buffer_stream_pkg::*;

  logic                  clk = 1'b0;
  logic                  rstn;
  logic                  cmd_valid, cmd_ready, cmd_write;
  logic [31:0]           cmd_base;
  logic [15:0]           cmd_len;
  logic [1:0]            cmd_slot, slot_sel;
  BufferRAMTEFsizeInputs ram_req;
  logic [31:0]           ram_rdata, wr_data, rd_data;
  logic                  wr_valid, wr_ready, rd_valid, busy, done;

  int n_total = 0;
  int n_pass  = 0;

  buffer_stream_port dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_base(cmd_base), .cmd_len(cmd_len), .cmd_slot(cmd_slot),
    .slot_sel(slot_sel), .ram_req(ram_req), .ram_rdata(ram_rdata),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Buffer slot: each word is a fixed function of its address, returned so the port
  // presents it on rd_data four cycles after the address appears.
  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  logic [31:0] pipe [3];
  always @(posedge clk) begin
    pipe[2] <= pipe[1];
    pipe[1] <= pipe[0];
    pipe[0] <= ram_req.raddr;
  end
  assign ram_rdata = word(pipe[2]);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  typedef struct {
    logic [31:0] base;
    logic [15:0] len;
    logic [1:0]  slot;
    logic [31:0] a [3];
    int          done_cyc;
  } rd_vec_t;

  function automatic rd_vec_t mk(input logic [31:0] base, input logic [15:0] len,
                                 input logic [1:0] slot, input logic [31:0] a0,
                                 input logic [31:0] a1, input logic [31:0] a2, input int d);
    rd_vec_t v;
    v.base = base; v.len = len; v.slot = slot;
    v.a[0] = a0; v.a[1] = a1; v.a[2] = a2;
    v.done_cyc = d;
    return v;
  endfunction

  // Cycle 0 is the cycle cmd_valid is sampled with cmd_ready; cycle c is c clocks later.
  task automatic run_read(input rd_vec_t v);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0;
    cmd_base = v.base; cmd_len = v.len; cmd_slot = v.slot;
    check("rd_cmd_ready", cmd_ready, 1'b1);
    for (int c = 1; c <= v.done_cyc + 2; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (c <= int'(v.len)) check("rd_raddr", ram_req.raddr, v.a[c-1]);
      check("rd_valid", rd_valid, (c >= 5) && (c <= v.done_cyc));
      if ((c >= 5) && (c <= v.done_cyc)) check("rd_data", rd_data, word(v.a[c-5]));
      check("rd_done", done, c == v.done_cyc);
      check("rd_busy", busy, c < v.done_cyc);
      check("rd_wren", ram_req.wren, 1'b0);
      check("rd_slot_sel", slot_sel, v.slot);
    end
  endtask

  rd_vec_t vecs [4];

  initial begin
    logic [8:1]  pat;
    logic        exp_wren;
    logic [31:0] exp_waddr, exp_wdata, exp_raddr, exp_rdw;

    vecs[0] = mk(32'h10,       16'd3, 2'd2, 32'h10,       32'h11,       32'h12,       7);
    vecs[1] = mk(32'hFFFFFFFE, 16'd3, 2'd1, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000, 7);
    vecs[2] = mk(32'h100,      16'd1, 2'd3, 32'h100,      32'h0,        32'h0,        5);
    vecs[3] = mk(32'h7,        16'd2, 2'd0, 32'h7,        32'h8,        32'h0,        6);

    rstn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_base = '0; cmd_len = '0;
    cmd_slot = '0; wr_data = '0; wr_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_wr_ready", wr_ready, 1'b0);
    check("rst_req", ram_req, '0);
    check("rst_slot_sel", slot_sel, 2'd0);
    rstn = 1'b1;

    for (int i = 0; i < 4; i++) run_read(vecs[i]);

    // Gapped write: beats in cycles 1,3,4,5; wr_valid in 6,7 lands outside WRITE.
    pat = 8'b0111_1101;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_base = 32'h20; cmd_len = 16'd4; cmd_slot = 2'd1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      exp_wren  = (c == 2) || (c == 4) || (c == 5) || (c == 6);
      exp_waddr = (c == 2) ? 32'h20 : (c == 4) ? 32'h21 : (c == 5) ? 32'h22 : 32'h23;
      exp_wdata = 32'hD000_0000 + ((c == 2) ? 32'd1 : (c >= 7) ? 32'd5 : 32'(c - 1));
      check("wr_wren", ram_req.wren, exp_wren);
      if (exp_wren || c >= 7) begin
        check("wr_waddr", ram_req.waddr, exp_waddr);
        check("wr_wdata", ram_req.wdata, exp_wdata);
      end
      check("wr_ready", wr_ready, (c >= 1) && (c <= 5));
      check("wr_done", done, c == 6);
      check("wr_busy", busy, c <= 5);
      check("wr_slot_sel", slot_sel, 2'd1);
      wr_valid = pat[c];
      wr_data  = 32'hD000_0000 + 32'(c);
    end
    wr_valid = 1'b0;

    // Zero-length command completes in place with no access.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_base = 32'h55; cmd_len = 16'd0; cmd_slot = 2'd3;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      check("z_done", done, c == 1);
      check("z_busy", busy, 1'b0);
      check("z_wren", ram_req.wren, 1'b0);
      check("z_rd_valid", rd_valid, 1'b0);
      check("z_cmd_ready", cmd_ready, 1'b1);
    end

    // Reset two cycles into a long read discards everything in flight.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_base = 32'h40; cmd_len = 16'd8; cmd_slot = 2'd2;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("ab_busy_before", busy, 1'b1);
    rstn = 1'b0;
    #1;
    check("ab_busy", busy, 1'b0);
    check("ab_cmd_ready", cmd_ready, 1'b1);
    check("ab_req", ram_req, '0);
    check("ab_slot_sel", slot_sel, 2'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("ab_rd_valid", rd_valid, 1'b0);
      check("ab_idle", busy, 1'b0);
    end
    run_read(mk(32'h50, 16'd2, 2'd1, 32'h50, 32'h51, 32'h0, 6));

    // cmd_valid held through a busy period: the next command is taken at the done cycle.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_base = 32'h200; cmd_len = 16'd1; cmd_slot = 2'd2;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) begin cmd_base = 32'h300; cmd_len = 16'd2; cmd_slot = 2'd0; end
      if (c == 6) cmd_valid = 1'b0;
      exp_raddr = (c <= 5) ? 32'h200 : (c == 6) ? 32'h300 : 32'h301;
      exp_rdw   = (c == 5) ? word(32'h200) : (c == 10) ? word(32'h300) : word(32'h301);
      check("bb_cmd_ready", cmd_ready, (c == 5) || (c >= 11));
      check("bb_busy", busy, (c <= 4) || ((c >= 6) && (c <= 10)));
      check("bb_done", done, (c == 5) || (c == 11));
      check("bb_raddr", ram_req.raddr, exp_raddr);
      check("bb_slot_sel", slot_sel, (c <= 5) ? 2'd2 : 2'd0);
      check("bb_rd_valid", rd_valid, (c == 5) || (c == 10) || (c == 11));
      if ((c == 5) || (c == 10) || (c == 11)) check("bb_rd_data", rd_data, exp_rdw);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
